// File: rtl/vector_alu_pkg.sv
// Shared constants and types for the vector ALU sequencer.
package vector_alu_pkg;

    localparam int NREGS  = 8;
    localparam int IDX_W  = $clog2(NREGS);
    localparam int DATA_W = 4;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OPC_ADD = 5'b00000;
    localparam logic [OP_W-1:0] OPC_SUB = 5'b00001;
    localparam logic [OP_W-1:0] OPC_AND = 5'b00010;
    localparam logic [OP_W-1:0] OPC_OR  = 5'b00011;
    localparam logic [OP_W-1:0] OPC_XOR = 5'b00100;
    localparam logic [OP_W-1:0] OPC_SHL = 5'b00101;
    localparam logic [OP_W-1:0] OPC_SHR = 5'b00110;
    localparam logic [OP_W-1:0] OPC_NOT = 5'b00111;
    localparam logic [OP_W-1:0] OPC_MUL = 5'b01000;
    localparam logic [OP_W-1:0] OPC_MSW = 5'b01001;
    localparam logic [OP_W-1:0] OPC_CMP = 5'b01010;
    localparam logic [OP_W-1:0] OPC_NOP = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } seq_state_t;

    // Instruction fields held for the life of one instruction.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [IDX_W-1:0] rd;
    } instr_lat_t;

endpackage

// File: rtl/vector_regfile.sv
// 8x4 register file: one write port, two read ports captured on enable,
// and a combinational debug read port.
module vector_regfile import vector_alu_pkg::*; #(
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  raddr_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [NREGS-1:0][DATA_W-1:0] regs;

    // Architectural register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs <= '0;
        else if (we) regs[waddr] <= wdata;
    end

    // Operand capture; values are frozen at capture so a later write to
    // the same register cannot disturb an in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (rd_en) begin
            rdata_a <= regs[raddr_a];
            rdata_b <= regs[raddr_b];
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/vector_alu_sequencer.sv
// Single-issue sequencer driving an external combinational 4-bit ALU.
// MUL retires in two write cycles (low nibble to rd, high to rd+1).
module vector_alu_sequencer import vector_alu_pkg::*; #(
    parameter int              NREGS  = 8,
    parameter logic [OP_W-1:0] OP_MUL = 5'b01000,
    parameter logic [OP_W-1:0] OP_MSW = 5'b01001,
    parameter logic [OP_W-1:0] OP_NOP = 5'b11111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [IDX_W-1:0]  instr_rd,
    input  logic [IDX_W-1:0]  instr_rs1,
    input  logic [IDX_W-1:0]  instr_rs2,
    output logic [DATA_W-1:0] alu_r,
    output logic [DATA_W-1:0] alu_s,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic [7:0]        alu_y2,
    output logic              done,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    seq_state_t        state, state_nx;
    instr_lat_t        ins_q;
    logic [DATA_W-1:0] prod_hi;
    logic [DATA_W-1:0] opr_r, opr_s;
    logic              hs;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;

    assign instr_ready = (state == IDLE);
    assign hs          = instr_valid && instr_ready;

    vector_regfile #(.NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .rd_en    (hs),
        .raddr_a  (instr_rs1),
        .raddr_b  (instr_rs2),
        .rdata_a  (opr_r),
        .rdata_b  (opr_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Latch opcode/destination at handshake; hold the MUL high nibble so
    // WB_LO and later MSW instructions can use it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_q   <= '{op: OP_NOP, rd: '0};
            prod_hi <= '0;
        end else begin
            if (hs) ins_q <= '{op: instr_op, rd: instr_rd};
            if (state == EXEC && ins_q.op == OP_MUL) prod_hi <= alu_y2[7:4];
        end
    end

    // Next-state, ALU drive, register write and retirement pulse.
    always_comb begin
        state_nx = state;
        alu_r    = '0;
        alu_s    = '0;
        alu_op   = OP_NOP;
        we       = 1'b0;
        waddr    = ins_q.rd;
        wdata    = alu_y;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) state_nx = EXEC;
            end
            EXEC: begin
                alu_r    = opr_r;
                alu_s    = opr_s;
                alu_op   = ins_q.op;
                state_nx = WB_LO;
                if (ins_q.op == OP_MUL) begin
                    we    = 1'b1;
                    wdata = alu_y2[3:0];
                end else if (ins_q.op == OP_MSW) begin
                    we    = 1'b1;
                    wdata = prod_hi;
                end else if (ins_q.op != OP_NOP) begin
                    we    = 1'b1;
                    wdata = alu_y;
                end
            end
            WB_LO: begin
                if (ins_q.op == OP_MUL) begin
                    // High nibble lands in the next register, wrapping 7 -> 0.
                    we       = 1'b1;
                    waddr    = ins_q.rd + IDX_W'(1);
                    wdata    = prod_hi;
                    state_nx = WB_HI;
                end else begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            WB_HI: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Scoreboard bench: the bench plays the ALU, keeps a register model, pushes
// the expected latency and register image per instruction and compares on done.
module tb_vector_alu_sequencer;
    import vector_alu_pkg::*;

    localparam logic [4:0] OPC_RSV_LO = 5'b01100;
    localparam logic [4:0] OPC_RSV_HI = 5'b11110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [4:0] instr_op = OPC_NOP;
    logic [2:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic [3:0] alu_r, alu_s;
    logic [4:0] alu_op;
    logic [3:0] alu_y;
    logic [7:0] alu_y2;
    logic       done;
    logic [2:0] dbg_addr = '0;
    logic [3:0] dbg_data;

    logic [3:0] imm = '0;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic [3:0]      lat;
        logic [7:0][3:0] regs;
    } exp_t;

    exp_t            sb[$];
    logic [7:0][3:0] m_regs = '0;
    logic [3:0]      m_prod_hi = '0;

    always #5 clk = ~clk;

    vector_alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .alu_r       (alu_r),
        .alu_s       (alu_s),
        .alu_op      (alu_op),
        .alu_y       (alu_y),
        .alu_y2      (alu_y2),
        .done        (done),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Reference ALU: returns {y2, y}. Reserved ops return imm so they double
    // as a register load; other unused codes return a marker value.
    function automatic logic [11:0] alu_fn(input logic [4:0] op, input logic [3:0] r,
                                           input logic [3:0] s, input logic [3:0] k);
        logic signed [7:0] a, b, p;
        logic [3:0] y;
        logic [7:0] y2;
        a  = {{4{r[3]}}, r};
        b  = {{4{s[3]}}, s};
        p  = a * b;
        y  = 4'h5;
        y2 = 8'hA5;
        case (op)
            OPC_ADD: y = r + s;
            OPC_SUB: y = r - s;
            OPC_AND: y = r & s;
            OPC_OR:  y = r | s;
            OPC_XOR: y = r ^ s;
            OPC_SHL: y = r << s[1:0];
            OPC_SHR: y = r >> s[1:0];
            OPC_NOT: y = ~r;
            OPC_CMP: y = {3'b000, (r < s)};
            OPC_MUL: begin y = p[3:0]; y2 = p; end
            default: if (op >= OPC_RSV_LO && op <= OPC_RSV_HI) y = k;
        endcase
        return {y2, y};
    endfunction

    always_comb {alu_y2, alu_y} = alu_fn(alu_op, alu_r, alu_s, imm);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic sweep(input string pfx, input logic [7:0][3:0] exp);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", pfx, i), dbg_data, exp[i]);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_hs(output bit ok);
        logic rdy;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk); rdy = instr_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        if (!ok) chk("hs_timeout", 0, 1);
        instr_valid = 1'b0;
        instr_op  = 5'($urandom);
        instr_rd  = 3'($urandom);
        instr_rs1 = 3'($urandom);
        instr_rs2 = 3'($urandom);
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        exp_t e;
        logic [11:0] a;
        logic [3:0] r, s;
        logic [2:0] rd1;
        bit ok, got;
        logic d;
        int lat;
        r   = m_regs[rs1];
        s   = m_regs[rs2];
        a   = alu_fn(op, r, s, imm);
        rd1 = rd + 3'd1;
        e.lat = 4'd2;
        if (op == OPC_MUL) begin
            m_regs[rd]  = a[7:4];
            m_prod_hi   = a[11:8];
            m_regs[rd1] = a[11:8];
            e.lat = 4'd3;
        end else if (op == OPC_MSW) begin
            m_regs[rd] = m_prod_hi;
        end else if (op != OPC_NOP) begin
            m_regs[rd] = a[3:0];
        end
        e.regs = m_regs;
        sb.push_back(e);

        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_valid = 1'b1;
        wait_hs(ok);

        lat = 0; got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("exec_alu_op", alu_op, op);
                chk("exec_alu_r", alu_r, r);
                chk("exec_alu_s", alu_s, s);
            end
            d = done;
            @(posedge clk); #1;
            lat++;
            if (d) got = 1'b1;
        end
        if (!got) chk("done_timeout", 0, 1);
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("done_one_cycle", done, 0);
        chk("ready_after", instr_ready, 1);
        chk("alu_op_idle", alu_op, OPC_NOP);
        sweep("reg", e.regs);
    endtask

    initial begin
        bit ok;
        int hs_cnt, done_cnt;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_alu_op", alu_op, OPC_NOP);
        chk("rst_alu_r", alu_r, 0);
        chk("rst_alu_s", alu_s, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sweep("rst", m_regs);

        // Load r1=3, r2=4 through reserved ops, then ADD
        imm = 4'h3; issue(OPC_RSV_LO, 3'd1, 3'd0, 3'd0);
        imm = 4'h4; issue(OPC_RSV_HI, 3'd2, 3'd0, 3'd0);
        issue(OPC_ADD, 3'd3, 3'd1, 3'd2);

        // MUL into r7 wraps the high nibble to r0; MSW picks it up
        issue(OPC_MUL, 3'd7, 3'd1, 3'd2);
        issue(OPC_MSW, 3'd2, 3'd0, 3'd0);

        // Signed MUL -3 * 5 = F1
        imm = 4'hD; issue(OPC_RSV_LO, 3'd1, 3'd0, 3'd0);
        imm = 4'h5; issue(OPC_RSV_LO, 3'd2, 3'd0, 3'd0);
        issue(OPC_MUL, 3'd4, 3'd1, 3'd2);
        issue(OPC_MSW, 3'd6, 3'd3, 3'd3);

        // rd aliases both sources
        imm = 4'h6; issue(OPC_RSV_LO, 3'd1, 3'd0, 3'd0);
        issue(OPC_ADD, 3'd1, 3'd1, 3'd1);
        issue(OPC_SUB, 3'd0, 3'd3, 3'd1);
        issue(OPC_XOR, 3'd3, 3'd4, 3'd5);
        issue(OPC_NOP, 3'd6, 3'd1, 3'd2);

        // NOP with valid held for four cycles
        hs_cnt = 0; done_cnt = 0;
        instr_op = OPC_NOP; instr_rd = 3'd4; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        instr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) instr_valid = 1'b0;
            @(negedge clk);
            if (instr_valid && instr_ready) hs_cnt++;
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        chk("nop_handshakes", hs_cnt, 2);
        chk("nop_dones", done_cnt, 2);
        sweep("nop", m_regs);

        // Reset while a MUL sits in WB_LO
        instr_op = OPC_MUL; instr_rd = 3'd2; instr_rs1 = 3'd6; instr_rs2 = 3'd4;
        instr_valid = 1'b1;
        wait_hs(ok);
        @(posedge clk); #1;
        chk("mid_done", done, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", instr_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_alu_op", alu_op, OPC_NOP);
        m_regs = '0; m_prod_hi = '0;
        sweep("mid_rst", m_regs);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        chk("abandon_no_done", done_cnt, 0);
        chk("post_rst_ready", instr_ready, 1);
        sweep("post_rst", m_regs);

        // Normal operation resumes, prod_hi cleared
        imm = 4'h9; issue(OPC_RSV_LO, 3'd3, 3'd0, 3'd0);
        issue(OPC_MSW, 3'd3, 3'd0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
